// File: rtl/cmp_pkg.sv
// Shared types and constants for the comparator arbiter and its clients.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int CMP_W = 4;

    localparam logic [2:0] RES_EQ = 3'b001;
    localparam logic [2:0] RES_LT = 3'b010;
    localparam logic [2:0] RES_GT = 3'b100;

endpackage

// File: rtl/comparator.sv
// Gate-level 4-bit unsigned magnitude comparator; bit 3 is the MSB.
module comparator (
    input  logic a0,
    input  logic a1,
    input  logic a2,
    input  logic a3,
    input  logic b0,
    input  logic b1,
    input  logic b2,
    input  logic b3,
    output logic AeqB,
    output logic AltB,
    output logic AgtB
);

    logic x0, x1, x2, x3;

    // x_i is high when bit i of both operands agrees.
    assign x0 = ~(a0 ^ b0);
    assign x1 = ~(a1 ^ b1);
    assign x2 = ~(a2 ^ b2);
    assign x3 = ~(a3 ^ b3);

    assign AeqB = x3 & x2 & x1 & x0;

    assign AgtB = (a3 & ~b3)
                | (x3 & a2 & ~b2)
                | (x3 & x2 & a1 & ~b1)
                | (x3 & x2 & x1 & a0 & ~b0);

    assign AltB = (~a3 & b3)
                | (x3 & ~a2 & b2)
                | (x3 & x2 & ~a1 & b1)
                | (x3 & x2 & x1 & ~a0 & b0);

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter that shares one 4-bit comparator between two requesters,
// sequencing each operand pair through IDLE -> CMP -> RESP.
module cmp_arbiter
    import cmp_pkg::*;
#(
    parameter int W         = 4,
    parameter int PRIO_INIT = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic [2:0]   rsp0_res,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [2:0]   rsp1_res,
    output logic         busy
);

    if (W != CMP_W) begin : g_bad_width
        $error("cmp_arbiter: W must equal the comparator width");
    end
    if (PRIO_INIT != 0 && PRIO_INIT != 1) begin : g_bad_prio
        $error("cmp_arbiter: PRIO_INIT must be 0 or 1");
    end

    state_t       state;
    logic         owner;
    logic         rr_ptr;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic [2:0]   res_q;
    logic         eq, lt, gt;
    logic         grant;
    logic         req_any;
    logic         rsp_ack;

    // Both valid: the pointer decides; otherwise whichever one is asking.
    assign grant   = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
    assign req_any = req0_valid || req1_valid;

    assign req0_ready = (state == IDLE) && req0_valid && !grant;
    assign req1_ready = (state == IDLE) && req1_valid &&  grant;

    assign rsp_ack = owner ? rsp1_ready : rsp0_ready;

    comparator u_comparator (
        .a0   (a_q[0]),
        .a1   (a_q[1]),
        .a2   (a_q[2]),
        .a3   (a_q[3]),
        .b0   (b_q[0]),
        .b1   (b_q[1]),
        .b2   (b_q[2]),
        .b3   (b_q[3]),
        .AeqB (eq),
        .AltB (lt),
        .AgtB (gt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            owner  <= 1'b0;
            rr_ptr <= PRIO_INIT[0];
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= 3'b000;
        end else begin
            case (state)
                IDLE: begin
                    if (req_any) begin
                        a_q   <= grant ? req1_a : req0_a;
                        b_q   <= grant ? req1_b : req0_b;
                        owner <= grant;
                        state <= CMP;
                    end
                end
                CMP: begin
                    res_q <= {gt, lt, eq};
                    state <= RESP;
                end
                RESP: begin
                    // The pointer only advances once a result has been consumed.
                    if (rsp_ack) begin
                        rr_ptr <= ~owner;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rsp0_valid = (state == RESP) && !owner;
    assign rsp1_valid = (state == RESP) &&  owner;
    assign rsp0_res   = rsp0_valid ? res_q : 3'b000;
    assign rsp1_res   = rsp1_valid ? res_q : 3'b000;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed bench for cmp_arbiter: arbitration order, latency, backpressure,
// mid-operation reset and an exhaustive operand sweep, checked via a scoreboard.
module tb_cmp_arbiter;
    import cmp_pkg::*;

    logic       clk;
    logic       rst;
    logic       req0_valid, req0_ready, rsp0_valid, rsp0_ready;
    logic       req1_valid, req1_ready, rsp1_valid, rsp1_ready;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0] rsp0_res, rsp1_res;
    logic       busy;

    int total = 0;
    int bad   = 0;

    // Scoreboard entry: {port, expected result}.
    logic [3:0] exp_q[$];

    cmp_arbiter #(.W(4), .PRIO_INIT(0)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_res   (rsp0_res),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_res   (rsp1_res),
        .busy       (busy)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] model(input logic [3:0] a, input logic [3:0] b);
        if (a == b)     return RES_EQ;
        else if (a < b) return RES_LT;
        else            return RES_GT;
    endfunction

    task automatic drive_step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive_step();
        rst = 1'b1;
        drive_step();
        drive_step();
        rst = 1'b0;
    endtask

    // ---------------- response monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (rsp0_valid) begin
                check("rsp1_idle_while_rsp0", {4'b0, rsp1_valid, rsp1_res}, 8'h00);
                check("rsp0_onehot", {7'b0, $onehot(rsp0_res)}, 8'h01);
            end
            if (rsp1_valid) begin
                check("rsp0_idle_while_rsp1", {4'b0, rsp0_valid, rsp0_res}, 8'h00);
                check("rsp1_onehot", {7'b0, $onehot(rsp1_res)}, 8'h01);
            end
            if (rsp0_valid && rsp0_ready) begin
                if (exp_q.size() == 0) check("rsp0_unexpected", 8'h01, 8'h00);
                else check("rsp0_result", {4'b0, 1'b0, rsp0_res}, {4'b0, exp_q.pop_front()});
            end
            if (rsp1_valid && rsp1_ready) begin
                if (exp_q.size() == 0) check("rsp1_unexpected", 8'h01, 8'h00);
                else check("rsp1_result", {4'b0, 1'b1, rsp1_res}, {4'b0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic       g;
        logic [3:0] a, b;

        rst = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; rsp0_ready = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; rsp1_ready = 1'b0;

        // Reset state.
        drive_step();
        drive_step();
        sample_step();
        check("reset_busy", {7'b0, busy}, 8'h00);
        check("reset_rsp_valid", {6'b0, rsp0_valid, rsp1_valid}, 8'h00);
        check("reset_rsp_res", {2'b0, rsp0_res, rsp1_res}, 8'h00);

        // Lone req0 5 vs 9: ready in first IDLE cycle, response two cycles later.
        drive_step();
        rst = 1'b0;
        req0_valid = 1'b1; req0_a = 4'd5; req0_b = 4'd9; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        sample_step();
        check("t1_ready", {6'b0, req0_ready, req1_ready}, 8'h02);
        exp_q.push_back({1'b0, RES_LT});
        drive_step();
        req0_valid = 1'b0;
        sample_step();
        check("t1_cmp", {5'b0, busy, rsp0_valid, rsp1_valid}, 8'h04);
        sample_step();
        check("t1_resp", {5'b0, busy, rsp0_valid, rsp1_valid}, 8'h06);
        sample_step();
        check("t1_back_idle", {7'b0, busy}, 8'h00);

        // Both requesters from reset: grants alternate starting with PRIO_INIT.
        do_reset();
        req0_valid = 1'b1; req0_a = 4'd12; req0_b = 4'd3;
        req1_valid = 1'b1; req1_a = 4'd7;  req1_b = 4'd7;
        g = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sample_step();
            check("t2_grant", {6'b0, req1_ready, req0_ready}, g ? 8'h02 : 8'h01);
            exp_q.push_back(g ? {1'b1, RES_EQ} : {1'b0, RES_GT});
            sample_step();
            check("t2_cmp_no_ready", {6'b0, req1_ready, req0_ready}, 8'h00);
            sample_step();
            g = ~g;
        end
        drive_step();
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Backpressure on rsp1 (0 vs 15) while req0 keeps asking.
        sample_step();
        drive_step();
        req1_valid = 1'b1; req1_a = 4'd0; req1_b = 4'd15; rsp1_ready = 1'b0;
        sample_step();
        check("t3_grant1", {6'b0, req1_ready, req0_ready}, 8'h02);
        exp_q.push_back({1'b1, RES_LT});
        drive_step();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd2;
        sample_step();
        check("t3_cmp_req0_ready", {7'b0, req0_ready}, 8'h00);
        for (int k = 0; k < 5; k++) begin
            sample_step();
            check("t3_stall_valid", {6'b0, rsp1_valid, busy}, 8'h03);
            check("t3_stall_res", {5'b0, rsp1_res}, {5'b0, RES_LT});
            check("t3_stall_req0_ready", {7'b0, req0_ready}, 8'h00);
        end
        drive_step();
        rsp1_ready = 1'b1;
        sample_step();
        check("t3_release_valid", {7'b0, rsp1_valid}, 8'h01);
        sample_step();
        check("t3_next_grant0", {6'b0, req1_ready, req0_ready}, 8'h01);
        exp_q.push_back({1'b0, RES_LT});
        drive_step();
        req0_valid = 1'b0;
        sample_step();
        sample_step();
        check("t3_req0_resp", {7'b0, rsp0_valid}, 8'h01);
        sample_step();

        // Reset during CMP of req0 15 vs 0: no response, pointer back to PRIO_INIT.
        drive_step();
        req0_valid = 1'b1; req0_a = 4'd15; req0_b = 4'd0;
        sample_step();
        check("t4_grant", {7'b0, req0_ready}, 8'h01);
        drive_step();
        req0_valid = 1'b0;
        rst = 1'b1;
        sample_step();
        check("t4_in_cmp", {7'b0, busy}, 8'h01);
        drive_step();
        rst = 1'b0;
        sample_step();
        check("t4_after_rst", {6'b0, busy, rsp0_valid}, 8'h00);
        for (int k = 0; k < 4; k++) begin
            sample_step();
            check("t4_no_rsp", {6'b0, rsp0_valid, rsp1_valid}, 8'h00);
        end
        drive_step();
        req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd3;
        req1_valid = 1'b1; req1_a = 4'd9; req1_b = 4'd4;
        sample_step();
        check("t4_ptr_reset", {6'b0, req1_ready, req0_ready}, 8'h01);
        exp_q.push_back({1'b0, RES_EQ});
        drive_step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        sample_step();
        sample_step();
        check("t4_rsp", {7'b0, rsp0_valid}, 8'h01);

        // Exhaustive sweep through req1: exactly three cycles per request.
        for (int i = 0; i < 256; i++) begin
            a = i[7:4];
            b = i[3:0];
            drive_step();
            req1_valid = 1'b1; req1_a = a; req1_b = b;
            sample_step();
            check("sweep_ready", {7'b0, req1_ready}, 8'h01);
            exp_q.push_back({1'b1, model(a, b)});
            drive_step();
            req1_valid = 1'b0;
            sample_step();
            check("sweep_cmp", {7'b0, rsp1_valid}, 8'h00);
            sample_step();
            check("sweep_resp", {7'b0, rsp1_valid}, 8'h01);
        end
        sample_step();
        check("sweep_idle", {7'b0, busy}, 8'h00);

        check("scoreboard_drained", exp_q.size() == 0 ? 8'h00 : 8'h01, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
